dma_rd_arbiter: RTL

- Shares the single DMA read channel (command stream plus returned 512-bit data stream) between two requesters, e.g. the reduce datapath and the control/ctrl read path.
- Arbitrates commands round-robin and forwards them to the DMA engine.
- Records the issuing requester per accepted command in an in-order route FIFO.
- Steers each returned data burst, delimited by last, to the requester that issued it.

---
 rtl/dma_rd_arbiter.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/dma_rd_arbiter.sv
// rtl/dma_rd_arbiter.sv - two-requester DMA read channel arbiter with in-order data return routing
module dma_rd_arbiter #(
  parameter int ADDR_W    = 64,
  parameter int LEN_W     = 32,
  parameter int DATA_W    = 512,
  parameter int MAX_OUTST = 4
) (
  input  logic                          clk,
  input  logic                          rstn,
  // requester 0 command
  input  logic                          s0_cmd_valid,
  output logic                          s0_cmd_ready,
  input  logic [ADDR_W-1:0]             s0_cmd_addr,
  input  logic [LEN_W-1:0]              s0_cmd_length,
  // requester 1 command
  input  logic                          s1_cmd_valid,
  output logic                          s1_cmd_ready,
  input  logic [ADDR_W-1:0]             s1_cmd_addr,
  input  logic [LEN_W-1:0]              s1_cmd_length,
  // command to DMA engine
  output logic                          m_cmd_valid,
  input  logic                          m_cmd_ready,
  output logic [ADDR_W-1:0]             m_cmd_addr,
  output logic [LEN_W-1:0]              m_cmd_length,
  // read data from DMA engine
  input  logic                          s_data_valid,
  output logic                          s_data_ready,
  input  logic [DATA_W-1:0]             s_data_data,
  input  logic [DATA_W/8-1:0]           s_data_keep,
  input  logic                          s_data_last,
  // data to requester 0
  output logic                          m0_data_valid,
  input  logic                          m0_data_ready,
  output logic [DATA_W-1:0]             m0_data_data,
  output logic [DATA_W/8-1:0]           m0_data_keep,
  output logic                          m0_data_last,
  // data to requester 1
  output logic                          m1_data_valid,
  input  logic                          m1_data_ready,
  output logic [DATA_W-1:0]             m1_data_data,
  output logic [DATA_W/8-1:0]           m1_data_keep,
  output logic                          m1_data_last,
  // status
  output logic [$clog2(MAX_OUTST+1)-1:0] outstanding,
  output logic [31:0]                   cmd_cnt0,
  output logic [31:0]                   cmd_cnt1
);

  localparam int PTR_W = $clog2(MAX_OUTST);
  localparam int CNT_W = $clog2(MAX_OUTST+1);
  localparam logic [CNT_W:0] FULL_CNT = (CNT_W+1)'(MAX_OUTST);

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  state_t state, state_nxt;

  // Round-robin preference: id of the requester that wins a tie next.
  logic             pref;
  // Id of the requester whose command is currently held in the m_cmd registers.
  logic             req_id;

  // Route FIFO: one requester id per command forwarded to the DMA engine.
  logic [MAX_OUTST-1:0] route_mem;
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [CNT_W-1:0]     count;

  logic             win_id;
  logic [LEN_W-1:0] win_len;
  logic             accept;
  logic             issue_done;
  logic             fifo_full;
  logic             fifo_empty;
  logic             head;
  logic             pop;
  logic [CNT_W:0]   reserved;

  // A command sitting in ISSUE already owns a FIFO slot, so it counts toward full.
  assign reserved   = {1'b0, count} + {{CNT_W{1'b0}}, (state == ISSUE)};
  assign fifo_full  = (reserved >= FULL_CNT);
  assign fifo_empty = (count == '0);
  assign head       = route_mem[rd_ptr];

  assign m_cmd_valid = (state == ISSUE);
  assign outstanding = count;

  // Data steering: the FIFO head decides which requester sees the current burst.
  assign m0_data_valid = s_data_valid & ~fifo_empty & ~head;
  assign m1_data_valid = s_data_valid & ~fifo_empty &  head;
  assign s_data_ready  = ~fifo_empty & (head ? m1_data_ready : m0_data_ready);
  assign m0_data_data  = s_data_data;
  assign m0_data_keep  = s_data_keep;
  assign m0_data_last  = s_data_last;
  assign m1_data_data  = s_data_data;
  assign m1_data_keep  = s_data_keep;
  assign m1_data_last  = s_data_last;

  // A burst retires its route entry on the beat carrying last.
  assign pop = s_data_valid & s_data_ready & s_data_last;

  // Command FSM state register.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Command FSM: round-robin grant in IDLE, hold the command in ISSUE until the DMA takes it.
  always_comb begin
    state_nxt    = state;
    s0_cmd_ready = 1'b0;
    s1_cmd_ready = 1'b0;
    win_id       = 1'b0;
    win_len      = '0;
    accept       = 1'b0;
    issue_done   = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_full && (s0_cmd_valid || s1_cmd_valid)) begin
          // Tie goes to the preferred requester; otherwise the only valid one wins.
          win_id       = s1_cmd_valid & (~s0_cmd_valid | pref);
          win_len      = win_id ? s1_cmd_length : s0_cmd_length;
          s0_cmd_ready = ~win_id;
          s1_cmd_ready = win_id;
          accept       = 1'b1;
          // Zero-length commands are swallowed here and never reach the DMA.
          if (win_len != '0) begin
            state_nxt = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (m_cmd_ready) begin
          issue_done = 1'b1;
          state_nxt  = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Captured command, preference, route FIFO and per-requester counters.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      pref         <= 1'b0;
      req_id       <= 1'b0;
      m_cmd_addr   <= '0;
      m_cmd_length <= '0;
      route_mem    <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      cmd_cnt0     <= '0;
      cmd_cnt1     <= '0;
    end else begin
      if (accept) begin
        pref <= ~win_id;
        if (win_len != '0) begin
          req_id       <= win_id;
          m_cmd_addr   <= win_id ? s1_cmd_addr : s0_cmd_addr;
          m_cmd_length <= win_len;
        end
      end
      if (issue_done) begin
        route_mem[wr_ptr] <= req_id;
        wr_ptr            <= wr_ptr + PTR_W'(1);
        if (req_id) begin
          cmd_cnt1 <= cmd_cnt1 + 32'd1;
        end else begin
          cmd_cnt0 <= cmd_cnt0 + 32'd1;
        end
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      // Simultaneous push and pop leave occupancy unchanged, including when full.
      case ({issue_done, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule
